// File: rtl/piano_pkg.sv
// Shared constants for the piano synth: key note frequencies and the
// half-period helpers used to size and load the tone counter.
package piano_pkg;

  localparam int MAX_KEYS = 8;

  // Note frequencies in Hz, C4 up to C5 (white keys).
  localparam int FREQ [0:MAX_KEYS-1] = '{32'd262, 32'd294, 32'd330, 32'd349,
                                         32'd392, 32'd440, 32'd494, 32'd523};

  // Tone half period in clock cycles for key k.
  function automatic int half_period(input int k, input int clk_hz);
    return clk_hz / (32'd2 * FREQ[k]);
  endfunction

  // Largest half period among the first n_keys keys. This sizes the tone counter.
  function automatic int max_half_period(input int n_keys, input int clk_hz);
    int m;
    m = 32'd0;
    for (int k = 0; k < n_keys; k++) begin
      if (half_period(k, clk_hz) > m) begin
        m = half_period(k, clk_hz);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/piano_synth_key_debounce.sv
// Single key front end: 2-flop synchronizer followed by a counting debouncer.
// The debounced state holds the raw active-low level; pressed is its inverse.
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          state_r;
  logic [DW-1:0] cnt_r;

  // Bring the asynchronous key level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= 1'b1;
      cnt_r   <= {DW{1'b0}};
    end else if (sync2_r == state_r) begin
      cnt_r   <= {DW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      state_r <= sync2_r;
      cnt_r   <= {DW{1'b0}};
    end else begin
      cnt_r   <= cnt_r + DW'(1'b1);
    end
  end

  assign pressed = ~state_r;

endmodule

// File: rtl/piano_synth.sv
// Single-voice piano: debounced keys, fixed-priority key select (lowest index
// wins) and a square-wave tone whose half period is shifted down by octave.
module piano_synth
  import piano_pkg::*;
#(
  parameter int N_KEYS          = 8,
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn,
  input  logic [1:0]        octave,
  output logic              speaker,
  output logic              note_valid,
  output logic [2:0]        note_idx
);

  localparam int HP_MAX = max_half_period(N_KEYS, CLK_HZ);
  localparam int CW     = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;

  logic [N_KEYS-1:0] pressed;
  logic              any_pressed;
  logic [2:0]        sel_idx;
  logic              note_valid_r;
  logic [2:0]        note_idx_r;
  logic [1:0]        octave_r;
  logic              change_s;
  logic [31:0]       hp_tab [MAX_KEYS];
  logic [31:0]       hp_shift;
  logic [CW-1:0]     hp_last;
  logic [CW-1:0]     cnt_r;
  logic              spk_r;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn[g]),
      .pressed(pressed[g])
    );
  end

  // Constant half-period table; unused upper keys are shorter than HP_MAX.
  for (genvar g = 0; g < MAX_KEYS; g++) begin : g_hp
    assign hp_tab[g] = 32'(half_period(g, CLK_HZ));
  end

  assign any_pressed = |pressed;

  // Fixed priority: scanning downwards leaves the lowest pressed index.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) begin
        sel_idx = 3'(i);
      end else begin
        sel_idx = sel_idx;
      end
    end
  end

  // Registered note state plus the octave it was last played at.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_valid_r <= 1'b0;
      note_idx_r   <= 3'd0;
      octave_r     <= 2'd0;
    end else begin
      note_valid_r <= any_pressed;
      note_idx_r   <= sel_idx;
      octave_r     <= octave;
    end
  end

  // Any change of note or octave restarts the tone from a clean low phase.
  assign change_s = (any_pressed != note_valid_r) || (sel_idx != note_idx_r) ||
                    (octave != octave_r);

  // Terminal count for the current note, never below a one-cycle half period.
  always_comb begin
    hp_shift = hp_tab[note_idx_r] >> octave_r;
    if (hp_shift > 32'd1) begin
      hp_last = CW'(hp_shift - 32'd1);
    end else begin
      hp_last = {CW{1'b0}};
    end
  end

  // Tone generator: count 0..HP-1, toggle the speaker on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      spk_r <= 1'b0;
    end else if (change_s || !note_valid_r) begin
      cnt_r <= {CW{1'b0}};
      spk_r <= 1'b0;
    end else if (cnt_r == hp_last) begin
      cnt_r <= {CW{1'b0}};
      spk_r <= ~spk_r;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign speaker    = spk_r;
  assign note_valid = note_valid_r;
  assign note_idx   = note_idx_r;

endmodule

// File: tb/tb_piano_synth.sv
// Scoreboard bench for piano_synth: every test pushes the expected output
// change events (cycle, note_valid, note_idx, speaker) and compares them
// against the change events recorded from the DUT.
module tb_piano_synth;

  localparam int N_KEYS = 3;
  localparam int CLK_HZ = 52400;
  localparam int DEB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn;
  logic [1:0]  octave;
  logic        speaker;
  logic        note_valid;
  logic [2:0]  note_idx;

  piano_synth #(
    .N_KEYS(N_KEYS), .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .octave(octave),
    .speaker(speaker), .note_valid(note_valid), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       v;
    logic [2:0] idx;
    logic       spk;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  e;
  ev_t  o;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [4:0] prev;

  // Reference tone model: start edge, half period, key, and whether sounding.
  int         ts_m = 0;
  int         hp_m = 1;
  int         pushed_to = 0;
  logic       on_m = 1'b0;
  logic [2:0] idx_m = 3'd0;

  function automatic logic spk_at(input int t);
    if (!on_m || t < ts_m) return 1'b0;
    return 1'(((t - ts_m) / hp_m) % 2);
  endfunction

  // One clock; outputs sampled at the falling edge, changes are recorded.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if ({note_valid, note_idx, speaker} !== prev) begin
      obs_q.push_back(ev_t'{cyc, note_valid, note_idx, speaker});
      prev = {note_valid, note_idx, speaker};
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Push expected speaker toggles of the current tone up to edge t.
  task automatic model_to(input int t);
    for (int x = pushed_to + 1; x <= t; x++) begin
      if (on_m && x > ts_m && ((x - ts_m) % hp_m) == 0)
        exp_q.push_back(ev_t'{x, 1'b1, idx_m, spk_at(x)});
    end
    if (t > pushed_to) pushed_to = t;
  endtask

  // New note state takes effect at edge x with the speaker restarted low.
  task automatic model_change(input int x, input logic v, input logic [2:0] idx,
                              input int hp, input logic note_chg);
    model_to(x - 1);
    if (note_chg || spk_at(x - 1))
      exp_q.push_back(ev_t'{x, v, (v ? idx : 3'd0), 1'b0});
    on_m = v; idx_m = idx; hp_m = hp; ts_m = x; pushed_to = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 3'b111; octave = 2'd0;
    run(2);
    n_cmp++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", note_valid); end
    n_cmp++; if (note_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", note_idx); end
    n_cmp++; if (speaker !== 1'b0) begin n_err++; $display("FAIL reset_speaker: got %0b want 0", speaker); end
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    pushed_to = cyc; ts_m = cyc; on_m = 1'b0;
  endtask

  task automatic test_glitch();
    btn = 3'b110; run(3);
    btn = 3'b111; run(30);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL glitch: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL glitch: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL glitch: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
    n_cmp++; if ({note_valid, speaker} !== 2'b00) begin n_err++; $display("FAIL glitch_quiet: got valid=%0b spk=%0b want 0 0", note_valid, speaker); end
  endtask

  task automatic test_single_key();
    int c;
    c = cyc; btn = 3'b110;
    model_change(c + 7, 1'b1, 3'd0, 100, 1'b1);
    run(350);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL single_key: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL single_key: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL single_key: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
  endtask

  task automatic test_octave();
    int c;
    c = cyc; octave = 2'd1;
    model_change(c + 1, 1'b1, 3'd0, 50, 1'b0);
    run(160);
    c = cyc; octave = 2'd3;
    model_change(c + 1, 1'b1, 3'd0, 12, 1'b0);
    run(40);
    c = cyc; octave = 2'd0;
    model_change(c + 1, 1'b1, 3'd0, 100, 1'b0);
    run(150);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL octave: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL octave: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL octave: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
  endtask

  task automatic test_reset_mid_tone();
    int c;
    c = cyc; rst = 1'b1;
    model_change(c + 1, 1'b0, 3'd0, 1, 1'b1);
    tick();
    rst = 1'b0;
    n_cmp++; if ({note_valid, note_idx, speaker} !== 5'b0) begin n_err++; $display("FAIL reset_mid_tone_outputs: got v=%0b idx=%0d spk=%0b want all 0", note_valid, note_idx, speaker); end
    model_change(cyc + 7, 1'b1, 3'd0, 100, 1'b1);
    run(230);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL reset_mid_tone: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL reset_mid_tone: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL reset_mid_tone: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
  endtask

  task automatic test_higher_no_effect();
    btn = 3'b010;
    run(80);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL higher_key: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL higher_key: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL higher_key: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
    n_cmp++; if (note_idx !== 3'd0) begin n_err++; $display("FAIL higher_key_idx: got %0d want 0", note_idx); end
  endtask

  task automatic test_release();
    int c;
    c = cyc; btn = 3'b111;
    model_change(c + 7, 1'b0, 3'd0, 1, 1'b1);
    run(40);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL release: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL release: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL release: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
    n_cmp++; if ({note_valid, note_idx, speaker} !== 5'b0) begin n_err++; $display("FAIL release_idle: got v=%0b idx=%0d spk=%0b want all 0", note_valid, note_idx, speaker); end
  endtask

  task automatic test_priority();
    int c;
    c = cyc; btn = 3'b011;
    model_change(c + 7, 1'b1, 3'd2, 79, 1'b1);
    run(120);
    c = cyc; btn = 3'b001;
    model_change(c + 7, 1'b1, 3'd1, 89, 1'b1);
    run(200);
    c = cyc; btn = 3'b011;
    model_change(c + 7, 1'b1, 3'd2, 79, 1'b1);
    run(180);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL priority: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL priority: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL priority: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
  endtask

  // Key 2 released and key 0 pressed on the same cycle, then everything released.
  task automatic test_back_to_back();
    int c;
    c = cyc; btn = 3'b110;
    model_change(c + 7, 1'b1, 3'd0, 100, 1'b1);
    run(150);
    c = cyc; btn = 3'b111;
    model_change(c + 7, 1'b0, 3'd0, 1, 1'b1);
    run(20);
    model_to(cyc);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_err++; $display("FAIL back_to_back: extra event cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk); end
      else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_err++; $display("FAIL back_to_back: missing event cyc=%0d v=%0b idx=%0d spk=%0b", e.cyc, e.v, e.idx, e.spk); end
      else begin e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL back_to_back: got cyc=%0d v=%0b idx=%0d spk=%0b want cyc=%0d v=%0b idx=%0d spk=%0b", o.cyc, o.v, o.idx, o.spk, e.cyc, e.v, e.idx, e.spk); end end
    end
    n_cmp++; if ({note_valid, note_idx, speaker} !== 5'b0) begin n_err++; $display("FAIL back_to_back_idle: got v=%0b idx=%0d spk=%0b want all 0", note_valid, note_idx, speaker); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_key();
    test_octave();
    test_reset_mid_tone();
    test_higher_no_effect();
    test_release();
    test_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piano_synth.md
PIANO_SYNTH -- requirements
Module: piano_synth

Interface
REQ-001 Parameters SHALL be: N_KEYS, default 8, number of keys (1..8); CLK_HZ, default 50_000_000, clock frequency in Hz; DEBOUNCE_CYCLES, default 500_000, stable-sample count required before a key change is accepted (>=1).
REQ-002 Ports SHALL be, clock and reset first: clk input 1 system clock; rst input 1 reset; btn input N_KEYS raw keys, active-low; octave input 2 octave shift 0..3; speaker output 1 square-wave tone; note_valid output 1 a key is sounding; note_idx output 3 index of the sounding key.
REQ-003 The block SHALL use a single clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 Each key SHALL have its own debouncer: a per-key counter clears whenever the synchronized sample equals the debounced state; the debounced state takes the sample when the counter reaches DEBOUNCE_CYCLES-1 differing samples in a row.
REQ-006 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced state unchanged.
REQ-007 The selected key SHALL be the lowest-index debounced-pressed key (fixed priority); pressing a higher index while a lower one is held SHALL have no effect.
REQ-008 note_valid and note_idx SHALL be registered: note_valid=1 iff any key is debounced-pressed; note_idx = selected index, or 0 when none is pressed.
REQ-009 The latency from a btn edge sampled at clk to the note_valid/note_idx update SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-010 The half period SHALL be HP = max(1, half_period(note_idx) >> octave) cycles, where half_period(k) = CLK_HZ / (2*FREQ[k]) (integer division, from the package).
REQ-011 While note_valid=1, the tone counter SHALL count 0..HP-1; on reaching HP-1 it SHALL wrap to 0 and toggle speaker.
REQ-012 On any change of note_idx, note_valid or octave, the counter SHALL reload to 0 and speaker SHALL go 0 on the same cycle; the new period starts fresh, with no partial old period.
REQ-013 While note_valid=0, speaker SHALL be 0 and the counter SHALL hold 0.
REQ-014 The counter width SHALL be $clog2 of the largest table entry; no overflow is permitted for any N_KEYS/CLK_HZ combination.
REQ-015 If all keys are released and one is pressed in the same cycle (debounced), the newly pressed key SHALL be selected and REQ-012 SHALL apply.

Reset
REQ-016 While rst=1 at a clk edge: synchronizers SHALL load the released value (1); debounced states SHALL be released; debounce counters, tone counter, speaker, note_valid and note_idx SHALL all be 0.
REQ-017 Reset asserted mid-tone SHALL force speaker=0 on the next edge. After release, a still-held key SHALL be re-debounced and SHALL sound DEBOUNCE_CYCLES+3 cycles after rst falls.

Structure
REQ-018 Package piano_pkg SHALL hold FREQ[0:7] = {262,294,330,349,392,440,494,523} Hz, the function half_period(k, clk_hz), and MAX_KEYS=8.
REQ-019 One sub-module SHALL exist, key_debounce (single key: synchronizer + debouncer), instantiated N_KEYS times with a generate loop.

Verification (N_KEYS=3, CLK_HZ=52400, DEBOUNCE_CYCLES=4: HP key0=100, key1=89, key2=79)
REQ-020 Press btn[0] (btn=3'b110), octave=0 -> note_valid=1 and note_idx=0 after 7 cycles; speaker toggles every 100 cycles, first rising edge 100 cycles after note_valid rises.
REQ-021 Hold btn[2], then add btn[1] -> note_idx goes 2->1, speaker drops to 0 the same cycle, then toggles every 89 cycles; release btn[1] -> note_idx=2 with an 79-cycle half period.
REQ-022 btn[0] low for 3 cycles, then high -> note_valid stays 0 and speaker stays 0 throughout.
REQ-023 key0 held, octave switched 0->1 mid-period -> counter restarts, speaker=0, then toggles every 50 cycles; octave=3 -> every 12 cycles.
REQ-024 rst=1 for 1 cycle mid-tone with key0 held -> all outputs 0 next cycle; note_valid returns 7 cycles after rst falls, speaker period 100.
REQ-025 Release all keys -> note_valid=0 after 7 cycles; speaker=0 and note_idx=0 from that cycle on.
